// File: rtl/game_2048_pkg.sv
// Shared definitions for the 2048 move engine.
//   - one-hot move direction codes
//   - move sequencer state type
//   - default-size line/board array types
//   - one-hot direction check helper
package game_2048_pkg;

    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [3:0] DIR_RIGHT = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        SLIDE,
        DONE
    } state_t;

    localparam int unsigned DEF_N = 4;
    localparam int unsigned DEF_W = 12;

    // Default-size containers; [row][col], row 0 top, col 0 left.
    typedef logic [0:DEF_N-1][DEF_W-1:0]             line_t;
    typedef logic [0:DEF_N-1][0:DEF_N-1][DEF_W-1:0]  board_t;

    function automatic logic dir_is_onehot(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one line, head at index 0.
// Ports:
//   line_in      N tiles, head first
//   goal         goal exponent; goal_hit when a merged tile >= 2**goal
//   line_out     merged line, head first, tail padded with 0
//   points       sum of tiles created by merges
//   goal_hit     some merge reached the goal
//   line_changed line_out differs from line_in
module line_merge
    import game_2048_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 12,
    parameter int unsigned PW = W + $clog2(N)
) (
    input  logic [0:N-1][W-1:0] line_in,
    input  logic [3:0]          goal,
    output logic [0:N-1][W-1:0] line_out,
    output logic [PW-1:0]       points,
    output logic                goal_hit,
    output logic                line_changed
);

    // Largest tile; doubling it would not fit in W bits, so it never merges.
    localparam logic [W-1:0] TILE_MAX = {1'b1, {(W-1){1'b0}}};

    // One extra always-zero slot so the pair compare at the tail stays in range.
    logic [0:N][W-1:0] comp;
    logic [W-1:0]      merged;
    logic              skip;
    int unsigned       cnt;
    int unsigned       pos;

    always_comb begin
        comp = '0;
        cnt  = 0;
        // Compact non-zero tiles toward the head, preserving order.
        for (int unsigned k = 0; k < N; k++) begin
            if (line_in[k] != '0) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (j == cnt) comp[j] = line_in[k];
                end
                cnt++;
            end
        end

        line_out = '0;
        points   = '0;
        goal_hit = 1'b0;
        merged   = '0;
        skip     = 1'b0;
        pos      = 0;
        // Pair scan from the head; skip consumes the partner so nothing cascades.
        for (int unsigned k = 0; k < N; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[k] != '0) begin
                if ((comp[k] == comp[k+1]) && (comp[k] != TILE_MAX)) begin
                    merged = comp[k] << 1;
                    points = points + PW'(merged);
                    if ((merged >> goal) != '0) goal_hit = 1'b1;
                    skip = 1'b1;
                end else begin
                    merged = comp[k];
                end
                for (int unsigned j = 0; j < N; j++) begin
                    if (j == pos) line_out[j] = merged;
                end
                pos++;
            end
        end

        line_changed = (line_out != line_in);
    end

endmodule

// File: rtl/move_engine_seq.sv
// Sequential 2048 move engine: one line per clock, results after N+1 cycles.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start           move request, accepted when ready
//   direction       one-hot LEFT/RIGHT/UP/DOWN
//   goal            goal exponent
//   board_in        current board [row][col]
//   ready           idle, start accepted
//   done            one-cycle result strobe
//   board_out       board after the move (held until next accepted start)
//   score           sum of merged tile values this move
//   changed         board_out differs from captured board
//   goal_reached    a merge produced a tile >= 2**goal
//   dir_error       direction was not one-hot (board passed through)
module move_engine_seq
    import game_2048_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 12,
    parameter int unsigned SW = W + 2*$clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 direction,
    input  logic [3:0]                 goal,
    input  logic [0:N-1][0:N-1][W-1:0] board_in,
    output logic                       ready,
    output logic                       done,
    output logic [0:N-1][0:N-1][W-1:0] board_out,
    output logic [SW-1:0]              score,
    output logic                       changed,
    output logic                       goal_reached,
    output logic                       dir_error
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = W + $clog2(N);

    state_t                       state, state_next;
    logic [0:N-1][0:N-1][W-1:0]   work, work_next;
    logic [3:0]                   dir_q, goal_q;
    logic [IW-1:0]                idx;
    logic [SW-1:0]                acc, acc_next;
    logic                         gr_acc, gr_next, ch_acc, ch_next, derr_q;
    logic                         dir_ok, last;
    logic [0:N-1][W-1:0]          line_head, line_new;
    logic [PW-1:0]                line_pts;
    logic                         line_goal, line_chg;

    assign dir_ok = dir_is_onehot(dir_q);
    assign last   = (idx == IW'(N - 1));

    line_merge #(.N(N), .W(W), .PW(PW)) u_line_merge (
        .line_in      (line_head),
        .goal         (goal_q),
        .line_out     (line_new),
        .points       (line_pts),
        .goal_hit     (line_goal),
        .line_changed (line_chg)
    );

    // Gather line idx into head-first order, and scatter the result back.
    always_comb begin
        line_head = '0;
        work_next = work;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                unique case (dir_q)
                    DIR_LEFT:  if (IW'(r) == idx) line_head[c]       = work[r][c];
                    DIR_RIGHT: if (IW'(r) == idx) line_head[N-1-c]   = work[r][c];
                    DIR_UP:    if (IW'(c) == idx) line_head[r]       = work[r][c];
                    DIR_DOWN:  if (IW'(c) == idx) line_head[N-1-r]   = work[r][c];
                    default: ;
                endcase
                if (state == SLIDE) begin
                    unique case (dir_q)
                        DIR_LEFT:  if (IW'(r) == idx) work_next[r][c] = line_new[c];
                        DIR_RIGHT: if (IW'(r) == idx) work_next[r][c] = line_new[N-1-c];
                        DIR_UP:    if (IW'(c) == idx) work_next[r][c] = line_new[r];
                        DIR_DOWN:  if (IW'(c) == idx) work_next[r][c] = line_new[N-1-r];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign acc_next = dir_ok ? (acc + SW'(line_pts)) : acc;
    assign gr_next  = gr_acc | (dir_ok & line_goal);
    assign ch_next  = ch_acc | (dir_ok & line_chg);

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = SLIDE;
            end
            SLIDE: if (last) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work         <= '0;
            dir_q        <= '0;
            goal_q       <= '0;
            idx          <= '0;
            acc          <= '0;
            gr_acc       <= 1'b0;
            ch_acc       <= 1'b0;
            derr_q       <= 1'b0;
            board_out    <= '0;
            score        <= '0;
            changed      <= 1'b0;
            goal_reached <= 1'b0;
            dir_error    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    work   <= board_in;
                    dir_q  <= direction;
                    goal_q <= goal;
                    idx    <= '0;
                    acc    <= '0;
                    gr_acc <= 1'b0;
                    ch_acc <= 1'b0;
                    derr_q <= !dir_is_onehot(direction);
                end
                SLIDE: begin
                    work   <= work_next;
                    acc    <= acc_next;
                    gr_acc <= gr_next;
                    ch_acc <= ch_next;
                    idx    <= idx + IW'(1);
                    // Publish on the last line so outputs change together with done.
                    if (last) begin
                        board_out    <= work_next;
                        score        <= acc_next;
                        changed      <= ch_next;
                        goal_reached <= gr_next;
                        dir_error    <= derr_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_engine_seq.sv
// Directed self-checking bench for move_engine_seq (N=4/W=12 and N=4/W=4).
module tb_move_engine_seq;
    import game_2048_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  direction = '0;
    logic [3:0]  goal = '0;
    board_t      board_in = '0;
    logic        ready, done, changed, goal_reached, dir_error;
    board_t      board_out;
    logic [15:0] score;

    logic                   start4 = 1'b0;
    logic [3:0]             dir4 = '0;
    logic [3:0]             goal4 = '0;
    logic [0:3][0:3][3:0]   board_in4 = '0;
    logic [0:3][0:3][3:0]   board_out4;
    logic                   ready4, done4, changed4, gr4, derr4;
    logic [7:0]             score4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    move_engine_seq u_dut (
        .clk(clk), .rst(rst), .start(start), .direction(direction), .goal(goal),
        .board_in(board_in), .ready(ready), .done(done), .board_out(board_out),
        .score(score), .changed(changed), .goal_reached(goal_reached), .dir_error(dir_error)
    );

    move_engine_seq #(.N(4), .W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .direction(dir4), .goal(goal4),
        .board_in(board_in4), .ready(ready4), .done(done4), .board_out(board_out4),
        .score(score4), .changed(changed4), .goal_reached(gr4), .dir_error(derr4)
    );

    function automatic logic [0:3][11:0] r12(input int a, input int b, input int c, input int d);
        return {12'(a), 12'(b), 12'(c), 12'(d)};
    endfunction

    function automatic logic [0:3][3:0] r4(input int a, input int b, input int c, input int d);
        return {4'(a), 4'(b), 4'(c), 4'(d)};
    endfunction

    // Drives one move; lat = negedge index (1 = first after accept) where done was seen, 0 if never.
    task automatic do_move(input board_t b, input logic [3:0] d, input logic [3:0] g,
                           output int lat, output board_t mid_board, output logic mid_ready);
        @(negedge clk);
        board_in = b; direction = d; goal = g; start = 1'b1;
        @(posedge clk);
        lat = 0; mid_board = '0; mid_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; mid_board = board_out; mid_ready = ready;
            end
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic do_move4(input logic [0:3][0:3][3:0] b, output int lat);
        @(negedge clk);
        board_in4 = b; dir4 = DIR_LEFT; goal4 = 4'd3; start4 = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start4 = 1'b0;
            if (done4) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #20;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (board_out !== '0) begin bad++; $display("FAIL reset_board got=%h exp=0", board_out); end
        total++; if ({score, changed, goal_reached, dir_error} !== '0) begin
            bad++; $display("FAIL reset_flags got=%h/%b%b%b exp=0", score, changed, goal_reached, dir_error); end
        total++; if (ready4 !== 1'b1) begin bad++; $display("FAIL reset_ready4 got=%b exp=1", ready4); end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_left;
        int lat; board_t mid; logic mr; board_t exp_b;
        do_move({r12(0,2,4,4), r12(2,2,8,8), r12(0,8,8,0), r12(4,4,8,4)}, DIR_LEFT, 4'd11, lat, mid, mr);
        exp_b = {r12(2,8,0,0), r12(4,16,0,0), r12(16,0,0,0), r12(8,8,4,0)};
        total++; if (lat !== 5) begin bad++; $display("FAIL left_latency got=%0d exp=5", lat); end
        total++; if (board_out !== exp_b) begin bad++; $display("FAIL left_board got=%h exp=%h", board_out, exp_b); end
        total++; if (score !== 16'd52) begin bad++; $display("FAIL left_score got=%0d exp=52", score); end
        total++; if ({changed, goal_reached, dir_error} !== 3'b100) begin
            bad++; $display("FAIL left_flags got=%b%b%b exp=100", changed, goal_reached, dir_error); end
        total++; if (mr !== 1'b0) begin bad++; $display("FAIL left_busy_ready got=%b exp=0", mr); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL left_done_width got=%b exp=0", done); end
        total++; if (board_out !== exp_b) begin bad++; $display("FAIL left_hold got=%h exp=%h", board_out, exp_b); end
    endtask

    task automatic test_up;
        int lat; board_t mid; logic mr; board_t exp_b; board_t prev;
        prev = {r12(2,8,0,0), r12(4,16,0,0), r12(16,0,0,0), r12(8,8,4,0)};
        do_move({r12(2,2,4,4), r12(2,8,8,8), r12(0,8,8,16), r12(0,0,0,16)}, DIR_UP, 4'd5, lat, mid, mr);
        exp_b = {r12(4,2,4,4), r12(0,16,16,8), r12(0,0,0,32), r12(0,0,0,0)};
        total++; if (mid !== prev) begin bad++; $display("FAIL up_hold_in_slide got=%h exp=%h", mid, prev); end
        total++; if (lat !== 5) begin bad++; $display("FAIL up_latency got=%0d exp=5", lat); end
        total++; if (board_out !== exp_b) begin bad++; $display("FAIL up_board got=%h exp=%h", board_out, exp_b); end
        total++; if (score !== 16'd68) begin bad++; $display("FAIL up_score got=%0d exp=68", score); end
        total++; if ({changed, goal_reached} !== 2'b11) begin
            bad++; $display("FAIL up_flags got=%b%b exp=11", changed, goal_reached); end
    endtask

    task automatic test_no_cascade;
        int lat; board_t mid; logic mr; board_t exp_b;
        do_move({r12(2,2,2,0), r12(0,0,0,0), r12(0,0,0,0), r12(0,0,0,0)}, DIR_RIGHT, 4'd3, lat, mid, mr);
        exp_b = {r12(0,0,2,4), r12(0,0,0,0), r12(0,0,0,0), r12(0,0,0,0)};
        total++; if (board_out !== exp_b) begin bad++; $display("FAIL right_board got=%h exp=%h", board_out, exp_b); end
        total++; if ({score, changed, goal_reached} !== {16'd4, 2'b10}) begin
            bad++; $display("FAIL right_score_flags got=%0d/%b%b exp=4/10", score, changed, goal_reached); end
        do_move({r12(2,0,0,0), r12(2,0,0,0), r12(2,0,0,0), r12(2,0,0,0)}, DIR_DOWN, 4'd2, lat, mid, mr);
        exp_b = {r12(0,0,0,0), r12(0,0,0,0), r12(4,0,0,0), r12(4,0,0,0)};
        total++; if (board_out !== exp_b) begin bad++; $display("FAIL down_board got=%h exp=%h", board_out, exp_b); end
        total++; if ({score, changed, goal_reached} !== {16'd8, 2'b11}) begin
            bad++; $display("FAIL down_score_flags got=%0d/%b%b exp=8/11", score, changed, goal_reached); end
    endtask

    task automatic test_noop_invalid;
        int lat; board_t mid; logic mr; board_t b;
        b = {r12(2,4,8,16), r12(2,4,8,16), r12(2,4,8,16), r12(2,4,8,16)};
        do_move(b, DIR_LEFT, 4'd1, lat, mid, mr);
        total++; if (board_out !== b) begin bad++; $display("FAIL noop_board got=%h exp=%h", board_out, b); end
        total++; if ({score, changed, goal_reached, dir_error} !== '0) begin
            bad++; $display("FAIL noop_flags got=%0d/%b%b%b exp=0/000", score, changed, goal_reached, dir_error); end
        b = {r12(0,2,4,4), r12(2,2,8,8), r12(0,8,8,0), r12(4,4,8,4)};
        do_move(b, 4'b1010, 4'd0, lat, mid, mr);
        total++; if (lat !== 5) begin bad++; $display("FAIL baddir_latency got=%0d exp=5", lat); end
        total++; if (board_out !== b) begin bad++; $display("FAIL baddir_board got=%h exp=%h", board_out, b); end
        total++; if ({score, changed, goal_reached, dir_error} !== {16'd0, 3'b001}) begin
            bad++; $display("FAIL baddir_flags got=%0d/%b%b%b exp=0/001", score, changed, goal_reached, dir_error); end
    endtask

    task automatic test_overflow_w4;
        int lat;
        do_move4({r4(8,8,0,0), r4(0,0,0,0), r4(0,0,0,0), r4(0,0,0,0)}, lat);
        total++; if (board_out4 !== {r4(8,8,0,0), r4(0,0,0,0), r4(0,0,0,0), r4(0,0,0,0)}) begin
            bad++; $display("FAIL ovf_board got=%h exp=8800000000000000", board_out4); end
        total++; if ({score4, changed4, gr4} !== 10'd0) begin
            bad++; $display("FAIL ovf_score_flags got=%0d/%b%b exp=0/00", score4, changed4, gr4); end
        do_move4({r4(4,4,0,0), r4(0,0,0,0), r4(0,0,0,0), r4(0,0,0,0)}, lat);
        total++; if (board_out4 !== {r4(8,0,0,0), r4(0,0,0,0), r4(0,0,0,0), r4(0,0,0,0)}) begin
            bad++; $display("FAIL w4_board got=%h exp=8000000000000000", board_out4); end
        total++; if ({score4, changed4, gr4} !== {8'd8, 2'b11}) begin
            bad++; $display("FAIL w4_score_flags got=%0d/%b%b exp=8/11", score4, changed4, gr4); end
    endtask

    task automatic test_reset_midmove;
        int dcount;
        @(negedge clk);
        board_in = {r12(0,2,4,4), r12(2,2,8,8), r12(0,8,8,0), r12(4,4,8,4)};
        direction = DIR_LEFT; goal = 4'd11; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (board_out !== '0) begin bad++; $display("FAIL midrst_board got=%h exp=0", board_out); end
        total++; if ({score, changed, goal_reached, dir_error} !== '0) begin
            bad++; $display("FAIL midrst_flags got=%0d/%b%b%b exp=0/000", score, changed, goal_reached, dir_error); end
        total++; if ({ready, done} !== 2'b10) begin bad++; $display("FAIL midrst_ready_done got=%b%b exp=10", ready, done); end
        @(negedge clk) rst = 1'b1;
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        total++; if (dcount !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", dcount); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after got=%b exp=1", ready); end
    endtask

    task automatic test_back_to_back;
        int dcount; int first;
        board_t exp_b;
        exp_b = {r12(0,0,2,4), r12(0,0,0,0), r12(0,0,0,0), r12(0,0,0,0)};
        @(negedge clk);
        board_in = {r12(2,2,2,0), r12(0,0,0,0), r12(0,0,0,0), r12(0,0,0,0)};
        direction = DIR_RIGHT; goal = 4'd11; start = 1'b1;
        @(posedge clk);
        dcount = 0; first = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                board_in = {r12(4,4,4,4), r12(4,4,4,4), r12(4,4,4,4), r12(4,4,4,4)};
                direction = DIR_LEFT; start = 1'b1;
            end
            if (k == 3) start = 1'b0;
            if (done) begin dcount++; if (first == 0) first = k; end
        end
        total++; if (dcount !== 1) begin bad++; $display("FAIL busy_start_dones got=%0d exp=1", dcount); end
        total++; if (first !== 5) begin bad++; $display("FAIL busy_start_latency got=%0d exp=5", first); end
        total++; if (board_out !== exp_b) begin bad++; $display("FAIL busy_start_board got=%h exp=%h", board_out, exp_b); end
    endtask

    initial begin
        test_reset;
        test_left;
        test_up;
        test_no_cascade;
        test_noop_invalid;
        test_overflow_w4;
        test_reset_midmove;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
